// File: rtl/div_ctrl_pkg.sv
// Shared constants and FSM state encoding for the divider issue controller.
package div_ctrl_pkg;

  localparam int DIV_W       = 32;
  localparam int DIV_NOM_LAT = 33;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_issue_ctrl.sv
// Sequences one DIV/DIVU request through the pipelined divider and returns the result on a
// valid/ready port. Optional macro DIV_ZERO_FAST_EN answers divide-by-zero without the divider.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter int WDOG_CYC = 40
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [DIV_W-1:0] req_x,
  input  logic [DIV_W-1:0] req_y,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             cancel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DIV_W-1:0] rsp_q,
  output logic [DIV_W-1:0] rsp_r,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             err,
  output logic             dv_div,
  output logic             dv_signed,
  output logic [DIV_W-1:0] dv_x,
  output logic [DIV_W-1:0] dv_y,
  input  logic [DIV_W-1:0] dv_s,
  input  logic [DIV_W-1:0] dv_r,
  input  logic             dv_complete
);

  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  div_state_t        state, state_nxt;
  logic [WDOG_W-1:0] wdog;
  logic              op_signed;
  logic [DIV_W-1:0]  op_x, op_y;
  logic [TAG_W-1:0]  op_tag;
  logic              accept, wdog_hit, zero_fast, waiting;

  assign accept   = req_valid && req_ready && !cancel;
  assign wdog_hit = (wdog == WDOG_W'(WDOG_CYC));
  assign waiting  = (state == WAIT) || (state == DRAIN);

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (req_y == '0);
`else
  assign zero_fast = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign dv_div    = (state == ISSUE);
  assign dv_signed = op_signed;
  assign dv_x      = op_x;
  assign dv_y      = op_y;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = zero_fast ? RESP : ISSUE;
      // Divider has already been started in ISSUE, so a cancel must drain it.
      ISSUE: state_nxt = cancel ? DRAIN : WAIT;
      WAIT: begin
        if (dv_complete)   state_nxt = cancel ? IDLE : RESP;
        else if (wdog_hit) state_nxt = IDLE;
        else if (cancel)   state_nxt = DRAIN;
      end
      RESP:  if (rsp_ready || cancel) state_nxt = IDLE;
      DRAIN: if (dv_complete || wdog_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state   <= IDLE;
      err     <= 1'b0;
      wdog    <= '0;
      rsp_q   <= '0;
      rsp_r   <= '0;
      rsp_tag <= '0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE)
        wdog <= '0;
      else if (waiting)
        wdog <= wdog + 1'b1;
      if (waiting && !dv_complete && wdog_hit)
        err <= 1'b1;
      if (state == WAIT && dv_complete && !cancel) begin
        rsp_q   <= dv_s;
        rsp_r   <= dv_r;
        rsp_tag <= op_tag;
      end
      if (accept && zero_fast) begin
        rsp_q   <= '1;
        rsp_r   <= req_x;
        rsp_tag <= req_tag;
      end
    end
  end

  // Operand capture at accept: held stable for the divider through ISSUE.
  always_ff @(posedge div_clk) begin
    if (accept) begin
      op_signed <= req_signed;
      op_x      <= req_x;
      op_y      <= req_y;
      op_tag    <= req_tag;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed scoreboard bench for div_issue_ctrl with a behavioural 33-cycle divider model.
module tb_div_issue_ctrl;

  localparam int TAG_W    = 4;
  localparam int WDOG_CYC = 40;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 35;
`endif

  logic             div_clk, resetn;
  logic             req_valid, req_ready, req_signed, cancel;
  logic [31:0]      req_x, req_y;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_q, rsp_r;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy, err;
  logic             dv_div, dv_signed, dv_complete;
  logic [31:0]      dv_x, dv_y, dv_s, dv_r;

  typedef struct packed {
    logic [31:0]      q;
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc = 0, dv_cnt = 0, prev_div_cyc = 0, last_div_cyc = 0;
  bit   stall_div = 0;
  logic [31:0] md_s, md_r;
  int   md_cnt = 0;

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .WDOG_CYC(WDOG_CYC)) dut (
    .div_clk(div_clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .cancel(cancel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_tag(rsp_tag), .busy(busy), .err(err),
    .dv_div(dv_div), .dv_signed(dv_signed), .dv_x(dv_x), .dv_y(dv_y),
    .dv_s(dv_s), .dv_r(dv_r), .dv_complete(dv_complete)
  );

  // RISC-V divide semantics, including /0 and signed overflow.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy, sq, sr;
    if (y == 32'h0) return {32'hFFFF_FFFF, x};
    if (!sgn) return {x / y, x % y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {x, 32'h0};
    sx = x;
    sy = y;
    sq = sx / sy;
    sr = sx % sy;
    return {sq, sr};
  endfunction

  // Divider model: complete pulses 33 cycles after the start pulse; results are garbage otherwise.
  always @(posedge div_clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      md_cnt      <= 0;
      dv_complete <= 1'b0;
      dv_s        <= 32'hDEAD_BEEF;
      dv_r        <= 32'hBAD0_BAD0;
    end else begin
      dv_complete <= 1'b0;
      dv_s        <= 32'hDEAD_BEEF;
      dv_r        <= 32'hBAD0_BAD0;
      if (dv_div) begin
        dv_cnt       <= dv_cnt + 1;
        prev_div_cyc <= last_div_cyc;
        last_div_cyc <= cyc;
        if (!stall_div) begin
          {md_s, md_r} <= ref_div(dv_signed, dv_x, dv_y);
          md_cnt       <= 32;
        end
      end else if (md_cnt != 0) begin
        md_cnt <= md_cnt - 1;
        if (md_cnt == 1) begin
          dv_complete <= 1'b1;
          dv_s        <= md_s;
          dv_r        <= md_r;
        end
      end
    end
  end

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one request for one cycle; returns at cycle T+1.
  task automatic send(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                      input logic [TAG_W-1:0] tag, input bit push,
                      input logic [31:0] eq, input logic [31:0] er);
    req_valid  = 1'b1;
    req_signed = sgn;
    req_x      = x;
    req_y      = y;
    req_tag    = tag;
    if (push) sb.push_back('{q: eq, r: er, tag: tag});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s_sb observed=unexpected_response expected=empty", name);
    end else begin
      total--;
      e = sb.pop_front();
      chk({name, "_q"}, rsp_q, e.q);
      chk({name, "_r"}, rsp_r, e.r);
      chk({name, "_tag"}, rsp_tag, e.tag);
    end
  endtask

  // Called at T+1; waits for rsp_valid, checks latency from T and pops the scoreboard.
  task automatic wait_rsp(input string name, input int lat);
    int n = 1;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_lat"}, n, lat);
    if (rsp_valid) pop_chk(name);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_req_ready"}, req_ready, 1'b1);
    chk({name, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_err"}, err, 1'b0);
    chk({name, "_dv_div"}, dv_div, 1'b0);
    chk({name, "_rsp_q"}, rsp_q, 32'h0);
    chk({name, "_rsp_r"}, rsp_r, 32'h0);
    chk({name, "_rsp_tag"}, rsp_tag, 4'h0);
  endtask

  initial begin
    int n, got, base;
    bit rsp_seen, rdy_seen;
    exp_t e;
    resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_x = '0; req_y = '0;
    req_tag = '0; cancel = 1'b0; rsp_ready = 1'b1;
    repeat (3) tick();
    chk_reset_vals("rst");
    resetn = 1'b1;
    tick();

    // DIVU 100/7
    base = dv_cnt;
    send(1'b0, 32'd100, 32'd7, 4'd3, 1, 32'd14, 32'd2);
    chk("t1_dv_div", dv_div, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_req_ready", req_ready, 1'b0);
    wait_rsp("t1", 35);
    tick();
    chk("t1_one_cycle", rsp_valid, 1'b0);
    chk("t1_starts", dv_cnt - base, 1);

    // Signed cases
    send(1'b1, 32'hFFFF_FFF9, 32'd2, 4'd4, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    wait_rsp("t2a", 35);
    tick();
    send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd5, 1, 32'h8000_0000, 32'h0);
    wait_rsp("t2b", 35);
    tick();

    // Cancel at T+10 drains the divider
    send(1'b0, 32'd1234, 32'd5, 4'd1, 0, 32'h0, 32'h0);
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n = 11; rsp_seen = 0; rdy_seen = 0;
    while (busy && n < 200) begin
      rsp_seen |= rsp_valid;
      rdy_seen |= req_ready;
      tick();
      n++;
    end
    chk("t3_idle_cyc", n, 35);
    chk("t3_no_rsp", rsp_seen, 1'b0);
    chk("t3_not_ready", rdy_seen, 1'b0);
    send(1'b0, 32'd9, 32'd3, 4'd6, 1, 32'd3, 32'd0);
    wait_rsp("t3b", 35);
    tick();

    // Cancel in IDLE blocks the request
    req_valid = 1'b1; cancel = 1'b1; req_x = 32'd8; req_y = 32'd2;
    tick();
    req_valid = 1'b0; cancel = 1'b0;
    chk("idle_cancel_busy", busy, 1'b0);

    // Backpressure: response held while rsp_ready low
    rsp_ready = 1'b0;
    send(1'b0, 32'd1000, 32'd10, 4'd7, 1, 32'd100, 32'd0);
    wait_rsp("t4", 35);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold_v", rsp_valid, 1'b1);
      chk("t4_hold_q", rsp_q, 32'd100);
      chk("t4_hold_r", rsp_r, 32'd0);
      chk("t4_hold_tag", rsp_tag, 4'd7);
    end
    rsp_ready = 1'b1;
    chk("t4_last_v", rsp_valid, 1'b1);
    tick();
    chk("t4_drop", rsp_valid, 1'b0);

    // Cancel in RESP drops the response
    rsp_ready = 1'b0;
    send(1'b0, 32'd50, 32'd5, 4'd8, 1, 32'd10, 32'd0);
    wait_rsp("rcan", 35);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("rcan_valid", rsp_valid, 1'b0);
    chk("rcan_busy", busy, 1'b0);
    rsp_ready = 1'b1;

    // Back-to-back with request held
    sb.push_back('{q: 32'd11, r: 32'd0, tag: 4'd9});
    sb.push_back('{q: 32'd11, r: 32'd0, tag: 4'd9});
    base = dv_cnt;
    req_valid = 1'b1; req_signed = 1'b0; req_x = 32'd77; req_y = 32'd7; req_tag = 4'd9;
    got = 0; n = 0;
    while (got < 2 && n < 150) begin
      tick();
      n++;
      if (dv_cnt >= base + 2) req_valid = 1'b0;
      if (rsp_valid) begin
        pop_chk("b2b");
        got++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_count", got, 2);
    chk("b2b_period", last_div_cyc - prev_div_cyc, 36);
    tick();

    // Watchdog with a stuck divider
    stall_div = 1;
    send(1'b0, 32'd1, 32'd1, 4'd11, 0, 32'h0, 32'h0);
    n = 1; rsp_seen = 0;
    while (!err && n < 200) begin
      rsp_seen |= rsp_valid;
      tick();
      n++;
    end
    chk("wdog_window", (n >= WDOG_CYC + 1) && (n <= WDOG_CYC + 3), 1'b1);
    chk("wdog_idle", busy, 1'b0);
    chk("wdog_ready", req_ready, 1'b1);
    chk("wdog_no_rsp", rsp_seen, 1'b0);
    stall_div = 0;
    send(1'b0, 32'd20, 32'd4, 4'd12, 1, 32'd5, 32'd0);
    wait_rsp("sticky", 35);
    chk("err_sticky", err, 1'b1);
    tick();

    // Reset mid-operation
    send(1'b0, 32'd123, 32'd4, 4'd10, 0, 32'h0, 32'h0);
    repeat (19) tick();
    resetn = 1'b0;
    tick();
    chk_reset_vals("t5");
    resetn = 1'b1;
    tick();
    send(1'b1, 32'hFFFF_FF9C, 32'd7, 4'd13, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    wait_rsp("t5b", 35);
    tick();

    // Divide by zero
    base = dv_cnt;
    send(1'b0, 32'd5, 32'd0, 4'd14, 1, 32'hFFFF_FFFF, 32'd5);
    wait_rsp("t6", ZLAT);
    tick();
`ifdef DIV_ZERO_FAST_EN
    chk("t6_no_start", dv_cnt - base, 0);
`else
    chk("t6_started", dv_cnt - base, 1);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
